// File: rtl/weight_loader.sv
// weight_loader: serial writer for a neuron weight/bias bank with atomic shadow-to-active commit
// Optional feature macro: WEIGHT_CHECKSUM_EN (adds CHECK state, running sum and chk_err).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   load_start, abort     frame start/restart pulse, frame drop
//   s_valid, s_data       stream word in; s_ready out (accept on s_valid && s_ready)
//   weights               active bank, word k at [k*WIDTH +: WIDTH] (index N_IN is the bias)
//   w_update              1-cycle pulse coincident with a new weights value
//   busy                  high whenever the loader is not idle
//   chk_err               1-cycle pulse on checksum mismatch (tied 0 without the macro)
module weight_loader #(
    parameter int N_IN  = 32,
    parameter int WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load_start,
    input  logic                        abort,
    input  logic                        s_valid,
    input  logic [WIDTH-1:0]            s_data,
    output logic                        s_ready,
    output logic [(N_IN+1)*WIDTH-1:0]   weights,
    output logic                        w_update,
    output logic                        busy,
    output logic                        chk_err
);
    localparam int IW = $clog2(N_IN + 2);
    localparam logic [IW-1:0] LAST = IW'(N_IN);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
`ifdef WEIGHT_CHECKSUM_EN
        CHECK,
`endif
        COMMIT
    } state_t;

    state_t           state_q;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] shadow_q  [N_IN+1];
    logic [WIDTH-1:0] weights_q [N_IN+1];
    logic             w_update_q;
`ifdef WEIGHT_CHECKSUM_EN
    logic [WIDTH-1:0] sum_q;
    logic             chk_err_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            w_update_q <= 1'b0;
            for (int k = 0; k <= N_IN; k++) begin
                shadow_q[k]  <= '0;
                weights_q[k] <= '0;
            end
`ifdef WEIGHT_CHECKSUM_EN
            sum_q      <= '0;
            chk_err_q  <= 1'b0;
`endif
        end else begin
            w_update_q <= 1'b0;
`ifdef WEIGHT_CHECKSUM_EN
            chk_err_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    // abort has priority over a simultaneous start
                    if (load_start && !abort) begin
                        state_q <= LOAD;
                        idx_q   <= '0;
`ifdef WEIGHT_CHECKSUM_EN
                        sum_q   <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else if (load_start) begin
                        // restart; a word presented on this edge is dropped
                        idx_q <= '0;
`ifdef WEIGHT_CHECKSUM_EN
                        sum_q <= '0;
`endif
                    end else if (s_valid) begin
                        shadow_q[idx_q] <= s_data;
`ifdef WEIGHT_CHECKSUM_EN
                        sum_q <= sum_q + s_data;
`endif
                        if (idx_q == LAST) begin
                            idx_q <= '0;
`ifdef WEIGHT_CHECKSUM_EN
                            state_q <= CHECK;
`else
                            state_q <= COMMIT;
`endif
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
`ifdef WEIGHT_CHECKSUM_EN
                CHECK: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else if (load_start) begin
                        state_q <= LOAD;
                        idx_q   <= '0;
                        sum_q   <= '0;
                    end else if (s_valid) begin
                        if (s_data == sum_q) begin
                            state_q <= COMMIT;
                        end else begin
                            state_q   <= IDLE;
                            chk_err_q <= 1'b1;
                        end
                    end
                end
`endif
                COMMIT: begin
                    // abort and load_start are ignored here: the commit always completes
                    weights_q  <= shadow_q;
                    w_update_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef WEIGHT_CHECKSUM_EN
    assign s_ready = (state_q == LOAD) || (state_q == CHECK);
    assign chk_err = chk_err_q;
`else
    assign s_ready = (state_q == LOAD);
    assign chk_err = 1'b0;
`endif
    assign busy     = (state_q != IDLE);
    assign w_update = w_update_q;

    for (genvar g = 0; g <= N_IN; g++) begin : g_pack
        assign weights[g*WIDTH +: WIDTH] = weights_q[g];
    end
endmodule
